keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
- Scans a 4x4 matrix keypad and debounces presses.
- Emits exactly one single-cycle key_valid pulse with a 4-bit hex key code per debounced press.
- Sits between the column synchronizer and the digit-history register that drives the two-digit seven-segment display.
- Replaces the separate scan FSM, row/column code latch and decoder with one block that has a clean valid-pulse output.

Parameters:
- SCAN_DIV, 48000, clk cycles each row is driven before advancing (1 ms at 48 MHz); must be >= 2.
- DEBOUNCE_CYCLES, 960000, consecutive stable cycles needed to accept a press or a release (20 ms at 48 MHz); must be >= 1.

Ports:
- clk  input  1  system clock (48 MHz HSOSC).
- resetInv  input  1  asynchronous, active-low reset.
- col  input  4  synchronized keypad columns, active-low (pull-ups; 0 = key in driven row closed).
- row  output  4  keypad row drive, one-hot active-low (exactly one bit 0 at all times).
- key  output  4  hex code of the last accepted key; holds its value between presses.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from the key_valid cycle until the release is debounced.

Behaviour:
- Reset (async, resetInv=0): row=4'b1110, key=0, key_valid=0, key_held=0, state=SCAN, all counters 0.
- Key map, row index r (row[r]=0), column index c (col[c]=0):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- A valid hit means exactly one col bit is 0. col=1111 means no key. Two or more zeros mean invalid and are treated as no key.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - div counter counts 0..SCAN_DIV-1 while a row is driven.
  - col is sampled only when div=SCAN_DIV-1, which gives SCAN_DIV-1 cycles of settling.
  - Valid hit at the sample: latch r and c, clear the debounce counter, go to DEBOUNCE; row stays frozen.
  - Otherwise: advance row to the next index (r3 wraps to r0) and reset div to 0.
- DEBOUNCE:
  - Each cycle, if col equals the latched pattern, increment cnt.
  - When cnt reaches DEBOUNCE_CYCLES-1 with a matching col: key<=map(r,c), key_valid=1 for the next cycle only, key_held=1, go to HELD.
  - Any mismatch: go to SCAN with row advanced to the next index and div=0. No pulse is emitted and key is unchanged.
- HELD:
  - Row stays frozen.
  - Stay while col[c]=0. Other columns are ignored, so a second key in the same row does not retrigger.
  - When col[c]=1: clear cnt and go to RELEASE.
- RELEASE:
  - Count consecutive cycles with col[c]=1.
  - If col[c]=0 reappears before the count completes: return to HELD with no new pulse.
  - When the count reaches DEBOUNCE_CYCLES-1: key_held=0, go to SCAN with row advanced to the next index and div=0.
- Keys in other rows are never seen while in DEBOUNCE, HELD or RELEASE, because only the frozen row is driven.
- Latency: key_valid is asserted exactly DEBOUNCE_CYCLES+1 cycles after the SCAN sample cycle that detected the hit.
- key_valid is never high in two consecutive cycles. There is at most one pulse per press-release sequence.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CYCLES+1). No overflow is possible.
- Reset mid-operation: async return to the reset state. Any pending press is discarded and no pulse is emitted.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset, col=1111 for 40 cycles:
  - row cycles 1110→1101→1011→0111→1110, 4 cycles per row.
  - key_valid stays 0.
- Model key "5" (r1,c1) held indefinitely:
  - row freezes at 1101.
  - key_valid pulses once, 9 cycles after the r1 sample cycle, with key=5 and key_held=1.
  - There is no further pulse while the key is held.
- Key "5" bounces (col toggles 1101/1111 every 3 cycles) for 30 cycles, then is stable:
  - No pulse during the bounce window.
  - Exactly one pulse with key=5 after 8 stable cycles.
- Release key "D" with a 3-cycle re-closure glitch after release:
  - Block returns to HELD with no second pulse.
  - After 8 clean released cycles: key_held=0 and scanning resumes at row 1110 (r3 wraps to r0).
- Press "1" and "2" together (r0, col=1100):
  - Treated as invalid: no pulse, scanning continues, key keeps its previous value.
- Assert resetInv=0 during DEBOUNCE of key "9":
  - Outputs immediately go to row=1110, key=0, key_valid=0, key_held=0.
  - No pulse after reset is released unless the key is re-debounced.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 4x4 keypad row scanner with press/release debounce and one-cycle key_valid
module keypad_scan_debounce #(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       resetInv,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t           state, state_nx;
    logic [1:0]       row_idx, row_idx_nx;
    logic [1:0]       col_idx, col_idx_nx;
    logic [3:0]       col_lat, col_lat_nx;
    logic [3:0]       key_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             key_valid_nx, key_held_nx;
    logic             hit;
    logic [1:0]       hit_col;

    function automatic logic [3:0] key_map(input logic [3:0] rc);
        case (rc)
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;
            4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    // Exactly one low column is a hit; multi-key patterns are discarded.
    always_comb begin
        hit     = 1'b1;
        hit_col = 2'd0;
        case (col)
            4'b1110: hit_col = 2'd0;
            4'b1101: hit_col = 2'd1;
            4'b1011: hit_col = 2'd2;
            4'b0111: hit_col = 2'd3;
            default: hit = 1'b0;
        endcase
    end

    assign row = ~(4'b0001 << row_idx);

    always_ff @(posedge clk or negedge resetInv) begin
        if (!resetInv) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            col_lat   <= 4'hF;
            div       <= '0;
            cnt       <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            row_idx   <= row_idx_nx;
            col_idx   <= col_idx_nx;
            col_lat   <= col_lat_nx;
            div       <= div_nx;
            cnt       <= cnt_nx;
            key       <= key_nx;
            key_valid <= key_valid_nx;
            key_held  <= key_held_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        row_idx_nx   = row_idx;
        col_idx_nx   = col_idx;
        col_lat_nx   = col_lat;
        div_nx       = div;
        cnt_nx       = cnt;
        key_nx       = key;
        key_valid_nx = 1'b0;
        key_held_nx  = key_held;
        case (state)
            SCAN: begin
                if (div == DIV_LAST) begin
                    div_nx = '0;
                    if (hit) begin
                        col_lat_nx = col;
                        col_idx_nx = hit_col;
                        cnt_nx     = '0;
                        state_nx   = DEBOUNCE;
                    end else begin
                        row_idx_nx = row_idx + 2'd1;
                    end
                end else begin
                    div_nx = div + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (col == col_lat) begin
                    if (cnt == CNT_LAST) begin
                        key_nx       = key_map({row_idx, col_idx});
                        key_valid_nx = 1'b1;
                        key_held_nx  = 1'b1;
                        state_nx     = HELD;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end else begin
                    row_idx_nx = row_idx + 2'd1;
                    div_nx     = '0;
                    state_nx   = SCAN;
                end
            end
            HELD: begin
                // Only the latched column matters; other keys in this row are ignored.
                if (col[col_idx]) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (!col[col_idx]) begin
                    state_nx = HELD;
                end else if (cnt == CNT_LAST) begin
                    key_held_nx = 1'b0;
                    row_idx_nx  = row_idx + 2'd1;
                    div_nx      = '0;
                    state_nx    = SCAN;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - self-checking bench for keypad_scan_debounce
module tb_keypad_scan_debounce;

    localparam int SD = 4;
    localparam int DC = 8;

    logic        clk      = 1'b0;
    logic        resetInv = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed  = 16'h0;
    logic        prev_valid = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  key_tbl[16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .resetInv  (resetInv),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad matrix: a pressed key pulls its column low only while its row is driven.
    always @* begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col[c] = 1'b0;
    end

    // Scoreboard: every key_valid pops one expected code.
    always @(negedge clk) begin
        if (resetInv && key_valid) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL back_to_back_pulse key_valid high two cycles in a row");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse key=%h expected no pulse", key);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key !== e) begin
                    errors++;
                    $display("FAIL pulse_key got=%h expected=%h", key, e);
                end
            end
            checks++;
            if (key_held !== 1'b1) begin
                errors++;
                $display("FAIL pulse_held got=%b expected=1", key_held);
            end
        end
        prev_valid = resetInv && key_valid;
    end

    task automatic wait_held(input logic lvl, input int limit, input string name);
        int n;
        n = 0;
        while (key_held !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_held !== lvl) begin
            errors++;
            $display("FAIL %s key_held=%b expected=%b within %0d cycles", name, key_held, lvl, limit);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        pressed  = 16'h0;
        resetInv = 1'b0;
        @(negedge clk);
        checks += 4;
        if (row !== 4'b1110)     begin errors++; $display("FAIL reset_row got=%b expected=1110", row); end
        if (key !== 4'h0)        begin errors++; $display("FAIL reset_key got=%h expected=0", key); end
        if (key_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b expected=0", key_valid); end
        if (key_held !== 1'b0)   begin errors++; $display("FAIL reset_held got=%b expected=0", key_held); end
        resetInv = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << ((k / SD) % 4));
            checks++;
            if (row !== exp_row) begin
                errors++;
                $display("FAIL scan_row cycle=%0d got=%b expected=%b", k, row, exp_row);
            end
        end
    endtask

    task automatic press_release(input int idx);
        pressed[idx] = 1'b1;
        exp_q.push_back(key_tbl[idx]);
        wait_held(1'b1, 200, "map_press");
        pressed = 16'h0;
        wait_held(1'b0, 200, "map_release");
        checks++;
        if (key !== key_tbl[idx]) begin
            errors++;
            $display("FAIL map_key_hold idx=%0d got=%h expected=%h", idx, key, key_tbl[idx]);
        end
    endtask

    task automatic test_key_map();
        for (int i = 0; i < 16; i++) press_release(i);
    endtask

    task automatic test_latency();
        int first_k, npulse;
        logic frozen_ok;
        first_k   = -1;
        npulse    = 0;
        frozen_ok = 1'b1;
        resetInv  = 1'b0;
        pressed   = 16'h0;
        pressed[5] = 1'b1;
        @(negedge clk);
        exp_q.push_back(4'h5);
        resetInv = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (key_valid) begin
                npulse++;
                if (first_k < 0) first_k = k;
            end
            if (k >= 2*SD && row !== 4'b1101) frozen_ok = 1'b0;
        end
        checks += 4;
        if (first_k != 2*SD + DC) begin errors++; $display("FAIL latency got=%0d expected=%0d", first_k, 2*SD + DC); end
        if (npulse != 1)          begin errors++; $display("FAIL held_single_pulse got=%0d expected=1", npulse); end
        if (!frozen_ok)           begin errors++; $display("FAIL row_frozen got=0 expected=1"); end
        if (key_held !== 1'b1)    begin errors++; $display("FAIL held_level got=%b expected=1", key_held); end
        pressed = 16'h0;
        wait_held(1'b0, 50, "latency_release");
    endtask

    task automatic test_bounce();
        int npulse;
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            pressed[5] = ((i / 3) % 2) == 0;
            @(negedge clk);
            if (key_valid) npulse++;
        end
        checks++;
        if (npulse != 0) begin errors++; $display("FAIL bounce_pulses got=%0d expected=0", npulse); end
        pressed[5] = 1'b1;
        exp_q.push_back(4'h5);
        npulse = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_valid) npulse++;
        end
        checks++;
        if (npulse != 1) begin errors++; $display("FAIL bounce_stable_pulses got=%0d expected=1", npulse); end
        pressed = 16'h0;
        wait_held(1'b0, 50, "bounce_release");
    endtask

    task automatic test_release_glitch();
        logic dropped;
        dropped = 1'b0;
        pressed[15] = 1'b1;
        exp_q.push_back(4'hD);
        wait_held(1'b1, 200, "glitch_press");
        pressed = 16'h0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) pressed[15] = 1'b1;
            @(negedge clk);
            if (key_held !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin errors++; $display("FAIL glitch_held got=0 expected=1"); end
        pressed = 16'h0;
        repeat (DC - 1) @(negedge clk);
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL release_early got=%b expected=1", key_held); end
        wait_held(1'b0, 20, "glitch_release");
        checks += 2;
        if (row !== 4'b1110) begin errors++; $display("FAIL release_row got=%b expected=1110", row); end
        if (key !== 4'hD)    begin errors++; $display("FAIL release_key got=%h expected=d", key); end
    endtask

    task automatic test_invalid();
        int npulse;
        logic saw_r1;
        npulse = 0;
        saw_r1 = 1'b0;
        pressed = 16'h0;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid) npulse++;
            if (row === 4'b1101) saw_r1 = 1'b1;
        end
        checks += 4;
        if (npulse != 0)       begin errors++; $display("FAIL invalid_pulses got=%0d expected=0", npulse); end
        if (!saw_r1)           begin errors++; $display("FAIL invalid_scan got=stalled expected=advancing"); end
        if (key !== 4'hD)      begin errors++; $display("FAIL invalid_key got=%h expected=d", key); end
        if (key_held !== 1'b0) begin errors++; $display("FAIL invalid_held got=%b expected=0", key_held); end
        pressed = 16'h0;
    endtask

    task automatic test_reset_mid();
        int n, npulse;
        n = 0;
        npulse = 0;
        pressed[10] = 1'b1;
        while (row !== 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (SD + 2) @(negedge clk);
        checks++;
        if (row !== 4'b1011) begin errors++; $display("FAIL debounce_frozen got=%b expected=1011", row); end
        #2 resetInv = 1'b0;
        #1;
        checks += 4;
        if (row !== 4'b1110)    begin errors++; $display("FAIL midreset_row got=%b expected=1110", row); end
        if (key !== 4'h0)       begin errors++; $display("FAIL midreset_key got=%h expected=0", key); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b expected=0", key_valid); end
        if (key_held !== 1'b0)  begin errors++; $display("FAIL midreset_held got=%b expected=0", key_held); end
        pressed = 16'h0;
        @(negedge clk);
        resetInv = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid) npulse++;
        end
        checks += 2;
        if (npulse != 0)  begin errors++; $display("FAIL midreset_pulses got=%0d expected=0", npulse); end
        if (key !== 4'h0) begin errors++; $display("FAIL midreset_key_after got=%h expected=0", key); end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_key_map();
        test_latency();
        test_bounce();
        test_release_glitch();
        test_invalid();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
